// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// parity/framing checks and a single-entry valid/ready output register.
module uart_rx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enable,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned     CntW      = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLoad  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LastData  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LastStop  = 4'(STOP_BITS - 1);
    localparam logic            HasParity = (PARITY != 0);
    localparam logic            OddParity = (PARITY == 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic                  sync_q, rxs_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  tick;
    logic                  frame_done;

    // Two-flop synchroniser; both flops reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= rx_in;
            rxs_q  <= sync_q;
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign tick    = (cnt_q == '0);
    assign rx_busy = (state_q != StIdle);

    // Next-state logic: every sample is taken when the bit counter reaches zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        if (!rx_enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        state_d = StStart;
                        cnt_d   = HalfLoad;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                StStart: begin
                    if (!tick) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else if (rxs_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = FullLoad;
                    end
                end
                StData: begin
                    if (!tick) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        // LSB arrives first, so shift in from the top.
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        cnt_d   = FullLoad;
                        if (idx_q == LastData) begin
                            idx_d   = '0;
                            state_d = HasParity ? StParity : StStop;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (!tick) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        perr_d  = (^shreg_q) ^ rxs_q ^ OddParity;
                        cnt_d   = FullLoad;
                        idx_d   = '0;
                        state_d = StStop;
                    end
                end
                StStop: begin
                    if (!tick) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        ferr_d = ferr_q | ~rxs_q;
                        cnt_d  = FullLoad;
                        if (idx_q == LastStop) begin
                            frame_done = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output slot: load on completion if free or being accepted, else flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else if (frame_done && (!rx_valid || rx_ready)) begin
            rx_data       <= shreg_q;
            rx_parity_err <= perr_q;
            rx_frame_err  <= ferr_d;
            rx_valid      <= 1'b1;
            if (rx_valid) begin
                rx_overrun <= 1'b0;
            end
        end else if (frame_done) begin
            rx_overrun <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four differently parametrised instances, a fixed vector
// table, hand-built corner sequences and random frames scored against a frame model.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic [3:0] rx_in_v, rdy_v;
    logic [3:0] valid_v, perr_v, ferr_v, ovr_v, busy_v;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [8:0] d3;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .rx_in(rx_in_v[0]), .rx_data(d0),
        .rx_valid(valid_v[0]), .rx_ready(rdy_v[0]), .rx_parity_err(perr_v[0]),
        .rx_frame_err(ferr_v[0]), .rx_overrun(ovr_v[0]), .rx_busy(busy_v[0]));
    uart_rx_param #(.DATA_BITS(7), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .rx_in(rx_in_v[1]), .rx_data(d1),
        .rx_valid(valid_v[1]), .rx_ready(rdy_v[1]), .rx_parity_err(perr_v[1]),
        .rx_frame_err(ferr_v[1]), .rx_overrun(ovr_v[1]), .rx_busy(busy_v[1]));
    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .rx_in(rx_in_v[2]), .rx_data(d2),
        .rx_valid(valid_v[2]), .rx_ready(rdy_v[2]), .rx_parity_err(perr_v[2]),
        .rx_frame_err(ferr_v[2]), .rx_overrun(ovr_v[2]), .rx_busy(busy_v[2]));
    uart_rx_param #(.DATA_BITS(9), .CLKS_PER_BIT(10), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .rx_in(rx_in_v[3]), .rx_data(d3),
        .rx_valid(valid_v[3]), .rx_ready(rdy_v[3]), .rx_parity_err(perr_v[3]),
        .rx_frame_err(ferr_v[3]), .rx_overrun(ovr_v[3]), .rx_busy(busy_v[3]));

    int errors = 0;
    int checks = 0;

    // Model of each instance's output slot.
    int m_valid[4], m_data[4], m_perr[4], m_ferr[4], m_ovr[4];

    typedef struct {
        int sel;
        int data;
        int pbit;
        int stop_pat;
        int e_data;
        int e_perr;
        int e_ferr;
    } vec_t;

    vec_t tbl[10];

    function automatic int cfg_dbits(int s);
        case (s)
            0: return 8;
            1: return 7;
            2: return 8;
            default: return 9;
        endcase
    endfunction

    function automatic int cfg_cpb(int s);
        case (s)
            0: return 16;
            1: return 16;
            2: return 4;
            default: return 10;
        endcase
    endfunction

    function automatic int cfg_par(int s);
        case (s)
            1: return 1;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stop(int s);
        return (s == 3) ? 2 : 1;
    endfunction

    function automatic logic [31:0] get_data(int s);
        case (s)
            0: return {24'd0, d0};
            1: return {25'd0, d1};
            2: return {24'd0, d2};
            default: return {23'd0, d3};
        endcase
    endfunction

    // Parity bit a correct transmitter would send for this word.
    function automatic int good_parity(int s, int data);
        logic [8:0] d;
        int ones;
        d = data[8:0];
        ones = 0;
        for (int i = 0; i < 9; i++) ones += int'(d[i]);
        if (cfg_par(s) == 2) return (ones % 2 == 0) ? 1 : 0;
        return ones % 2;
    endfunction

    function automatic int model_perr(int s, int data, int pbit);
        if (cfg_par(s) == 0) return 0;
        return (pbit != good_parity(s, data)) ? 1 : 0;
    endfunction

    function automatic int model_ferr(int s, int stop_pat);
        for (int i = 0; i < cfg_stop(s); i++) if (stop_pat[i] == 1'b0) return 1;
        return 0;
    endfunction

    // Clock edges from driving the start bit to rx_valid being visible.
    function automatic int exp_latency(int s);
        int n;
        n = cfg_dbits(s) + ((cfg_par(s) != 0) ? 1 : 0) + cfg_stop(s);
        return cfg_cpb(s) / 2 + n * cfg_cpb(s) + 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int s, input string tag);
        chk({tag, " valid"}, 32'(valid_v[s]), m_valid[s]);
        chk({tag, " data"}, get_data(s), m_data[s]);
        chk({tag, " perr"}, 32'(perr_v[s]), m_perr[s]);
        chk({tag, " ferr"}, 32'(ferr_v[s]), m_ferr[s]);
        chk({tag, " ovr"}, 32'(ovr_v[s]), m_ovr[s]);
        chk({tag, " busy"}, 32'(busy_v[s]), 0);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 0; m_data[s] = 0; m_perr[s] = 0; m_ferr[s] = 0; m_ovr[s] = 0;
        end
    endtask

    task automatic model_frame(input int s, input int data, input int perr, input int ferr,
                               input int accepted_same_cycle);
        if (m_valid[s] == 0 || accepted_same_cycle != 0) begin
            m_data[s] = data; m_perr[s] = perr; m_ferr[s] = ferr; m_valid[s] = 1;
            if (accepted_same_cycle != 0) m_ovr[s] = 0;
        end else begin
            m_ovr[s] = 1;
        end
    endtask

    task automatic build(input int s, input int data, input int pbit, input int stop_pat,
                         output logic [15:0] bits, output int nb);
        bits = '1;
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < cfg_dbits(s); i++) begin bits[nb] = data[i]; nb++; end
        if (cfg_par(s) != 0) begin bits[nb] = pbit[0]; nb++; end
        for (int i = 0; i < cfg_stop(s); i++) begin bits[nb] = stop_pat[i]; nb++; end
    endtask

    // Drive one frame starting just after an edge; report the edge at which rx_valid rose.
    task automatic send(input int s, input logic [15:0] bits, input int nb, input int tail,
                        input int ready_edge, output int rise);
        int   c;
        logic prev;
        c = cfg_cpb(s);
        prev = valid_v[s];
        rise = -1;
        for (int e = 0; e < nb * c + tail; e++) begin
            rx_in_v[s] = (e / c < nb) ? bits[e / c] : 1'b1;
            if (e + 1 == ready_edge) rdy_v[s] = 1'b1;
            @(posedge clk);
            #1;
            rdy_v[s] = 1'b0;
            if (!prev && valid_v[s] && rise < 0) rise = e + 1;
            prev = valid_v[s];
        end
        rx_in_v[s] = 1'b1;
    endtask

    task automatic accept(input int s);
        rdy_v[s] = 1'b1;
        @(posedge clk);
        #1;
        rdy_v[s] = 1'b0;
        if (m_valid[s] != 0) begin m_valid[s] = 0; m_ovr[s] = 0; end
    endtask

    task automatic frame(input int s, input int data, input int pbit, input int stop_pat,
                         input int tail, input int ready_edge, output int rise);
        logic [15:0] bits;
        int nb;
        build(s, data, pbit, stop_pat, bits, nb);
        send(s, bits, nb, tail, ready_edge, rise);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, s, db, data, pbit, spat, was_valid, saw_busy;
        logic [15:0] bits;
        int nb;

        rst = 1'b1; rx_enable = 1'b1; rx_in_v = '1; rdy_v = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) check_out(i, "reset");

        tbl[0] = '{0, 'hA5,  0, 1,    'hA5,  0, 0};
        tbl[1] = '{1, 'h41,  0, 1,    'h41,  0, 0};
        tbl[2] = '{1, 'h41,  1, 1,    'h41,  1, 0};
        tbl[3] = '{2, 'h41,  1, 1,    'h41,  0, 0};
        tbl[4] = '{2, 'h41,  0, 1,    'h41,  1, 0};
        tbl[5] = '{0, 'h3C,  0, 0,    'h3C,  0, 1};
        tbl[6] = '{3, 'h1FF, 0, 'b01, 'h1FF, 0, 1};
        tbl[7] = '{3, 'h0AA, 0, 'b11, 'h0AA, 0, 0};
        tbl[8] = '{1, 'h7F,  0, 1,    'h7F,  1, 0};
        tbl[9] = '{2, 'h00,  1, 1,    'h00,  0, 0};

        for (int i = 0; i < 10; i++) begin
            s = tbl[i].sel;
            frame(s, tbl[i].data, tbl[i].pbit, tbl[i].stop_pat, 4, 0, rise);
            chk($sformatf("tbl%0d latency", i), rise, exp_latency(s));
            chk($sformatf("tbl%0d valid", i), 32'(valid_v[s]), 1);
            chk($sformatf("tbl%0d data", i), get_data(s), tbl[i].e_data);
            chk($sformatf("tbl%0d perr", i), 32'(perr_v[s]), tbl[i].e_perr);
            chk($sformatf("tbl%0d ferr", i), 32'(ferr_v[s]), tbl[i].e_ferr);
            chk($sformatf("tbl%0d busy", i), 32'(busy_v[s]), 0);
            model_frame(s, tbl[i].e_data, tbl[i].e_perr, tbl[i].e_ferr, 0);
            repeat (5) @(posedge clk);
            #1;
            chk($sformatf("tbl%0d hold", i), 32'(valid_v[s]), 1);
            accept(s);
            chk($sformatf("tbl%0d drop", i), 32'(valid_v[s]), 0);
        end

        // Short low glitch: start bit fails its mid-bit check.
        saw_busy = 0;
        rx_in_v[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) rx_in_v[0] = 1'b1;
            @(posedge clk); #1;
            if (busy_v[0]) saw_busy = 1;
        end
        chk("glitch busy pulse", saw_busy, 1);
        check_out(0, "glitch");

        // Back-to-back frames with the slot occupied: second one is dropped.
        frame(0, 'h11, 0, 1, 0, 0, rise);
        chk("ovr first latency", rise, exp_latency(0));
        model_frame(0, 'h11, 0, 0, 0);
        frame(0, 'h22, 0, 1, 4, 0, rise);
        model_frame(0, 'h22, 0, 0, 0);
        check_out(0, "overrun");
        accept(0);
        check_out(0, "overrun cleared");

        // Completion coinciding with an accepting handshake.
        frame(0, 'h5A, 0, 1, 4, 0, rise);
        model_frame(0, 'h5A, 0, 0, 0);
        frame(0, 'hC3, 0, 1, 4, exp_latency(0), rise);
        model_frame(0, 'hC3, 0, 0, 1);
        check_out(0, "simultaneous");

        // Drop rx_enable in the middle of data bit 3; held output must survive.
        build(0, 'h33, 0, 1, bits, nb);
        for (int e = 0; e < 4 * 16 + 8; e++) begin
            rx_in_v[0] = bits[e / 16];
            @(posedge clk); #1;
        end
        rx_enable = 1'b0;
        rx_in_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort busy", 32'(busy_v[0]), 0);
        rx_enable = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_out(0, "abort");
        accept(0);

        // Random frames against the slot model.
        for (int it = 0; it < 40; it++) begin
            s = $urandom_range(0, 3);
            db = cfg_dbits(s);
            data = int'($urandom) & ((1 << db) - 1);
            pbit = good_parity(s, data);
            if ($urandom_range(0, 3) == 0) pbit = 1 - pbit;
            spat = (1 << cfg_stop(s)) - 1;
            if ($urandom_range(0, 4) == 0) spat = $urandom_range(0, (1 << cfg_stop(s)) - 2);
            was_valid = m_valid[s];
            frame(s, data, pbit, spat, 4, 0, rise);
            model_frame(s, data, model_perr(s, data, pbit), model_ferr(s, spat), 0);
            if (was_valid == 0) chk($sformatf("rnd%0d latency", it), rise, exp_latency(s));
            check_out(s, $sformatf("rnd%0d", it));
            if ($urandom_range(0, 3) != 0) begin
                accept(s);
                check_out(s, $sformatf("rnd%0d acc", it));
            end
        end

        // Reset in the middle of a frame, between clock edges.
        accept(0);
        frame(0, 'h96, 0, 1, 4, 0, rise);
        model_frame(0, 'h96, 0, 0, 0);
        build(0, 'h3C, 0, 1, bits, nb);
        for (int e = 0; e < 50; e++) begin
            rx_in_v[0] = bits[e / 16];
            @(posedge clk); #1;
        end
        chk("pre-rst busy", 32'(busy_v[0]), 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_out(0, "async rst");
        rx_in_v = '1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_out(0, "post rst");
        check_out(3, "post rst u3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
